// File: rtl/controladora_pkg.sv
// controladora_pkg: shared state type and counter-width helpers for the lighting controller
package controladora_pkg;
  typedef enum logic [1:0] {AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON} ctrl_state_t;
  function automatic int cnt_w(int p);
    return $clog2(p + 1);
  endfunction
  function automatic logic is_manual(ctrl_state_t s);
    return s == MANUAL_OFF || s == MANUAL_ON;
  endfunction
endpackage

// File: rtl/controladora_iluminacao_debounce.sv
// debounce: output level follows din only after DEBOUNCE_P consecutive differing samples
module debounce
  import controladora_pkg::*;
#(
  parameter int DEBOUNCE_P = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int W = cnt_w(DEBOUNCE_P);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == W'(DEBOUNCE_P - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/controladora_iluminacao.sv
// controladora_iluminacao: PIR/button lamp controller; CTRL_INPUT_SYNC_EN adds 2-flop input synchronizers
module controladora_iluminacao
  import controladora_pkg::*;
#(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int AUTO_SHUTDOWN_T   = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic infravermelho,
  input  logic push_button,
  output logic led,
  output logic saida
);
  localparam int PW = cnt_w(SWITCH_MODE_MIN_T);
  localparam int IW = cnt_w(AUTO_SHUTDOWN_T);
  logic pir, btn;
`ifdef CTRL_INPUT_SYNC_EN
  logic [1:0] pir_s, btn_s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pir_s <= '0;
      btn_s <= '0;
    end else begin
      pir_s <= {pir_s[0], infravermelho};
      btn_s <= {btn_s[0], push_button};
    end
  assign pir = pir_s[1];
  assign btn = btn_s[1];
`else
  assign pir = infravermelho;
  assign btn = push_button;
`endif
  logic btn_db, btn_q, release_ev, long_press;
  logic [PW-1:0] press_cnt;
  logic [IW-1:0] idle_cnt, idle_n, idle_inc;
  ctrl_state_t state, state_n;
  debounce #(.DEBOUNCE_P(DEBOUNCE_P)) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn),
    .dout(btn_db)
  );
  assign release_ev = btn_q & ~btn_db;
  assign long_press = press_cnt >= PW'(SWITCH_MODE_MIN_T);
  assign idle_inc   = idle_cnt + IW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= AUTO_OFF;
      btn_q     <= 1'b0;
      press_cnt <= '0;
      idle_cnt  <= '0;
      led       <= 1'b0;
      saida     <= 1'b0;
    end else begin
      state     <= state_n;
      btn_q     <= btn_db;
      press_cnt <= !btn_db ? '0 : long_press ? press_cnt : press_cnt + PW'(1);
      idle_cnt  <= idle_n;
      led       <= is_manual(state_n);
      saida     <= state_n == AUTO_ON || state_n == MANUAL_ON;
    end
  // a release outranks presence/timeout; an ignored short press in AUTO falls through
  always_comb begin
    state_n = state;
    idle_n  = idle_cnt;
    if (release_ev && long_press) begin
      state_n = is_manual(state) ? AUTO_OFF : MANUAL_OFF;
      idle_n  = '0;
    end else if (release_ev && is_manual(state)) begin
      state_n = state == MANUAL_ON ? MANUAL_OFF : MANUAL_ON;
    end else if (!is_manual(state)) begin
      if (pir) begin
        state_n = AUTO_ON;
        idle_n  = '0;
      end else if (state == AUTO_ON) begin
        state_n = idle_inc == IW'(AUTO_SHUTDOWN_T) ? AUTO_OFF : AUTO_ON;
        idle_n  = idle_inc == IW'(AUTO_SHUTDOWN_T) ? '0 : idle_inc;
      end
    end
  end
endmodule

// File: tb/tb_controladora_iluminacao.sv
// tb_controladora_iluminacao: randomized scoreboard bench against a timestamp-based reference model
module tb_controladora_iluminacao;
  localparam int P  = 30;
  localparam int SW = 500;
  localparam int T  = 3000;
  logic clk = 0, rst = 0, infravermelho = 0, push_button = 0;
  logic led, saida;
  int checks = 0, failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;
  always #5 clk = ~clk;
  controladora_iluminacao #(.DEBOUNCE_P(P), .SWITCH_MODE_MIN_T(SW), .AUTO_SHUTDOWN_T(T)) dut (
    .clk(clk), .rst(rst), .infravermelho(infravermelho), .push_button(push_button),
    .led(led), .saida(saida)
  );
  int cyc, run, rise_e, plen, last_pres;
  bit db, pend, man, lamp, do_auto;
  // model: debounced level, press length from rise/fall timestamps, timeout from last presence time
  always @(posedge clk) begin
    if (!rst) begin
      cyc = 0; run = 0; db = 0; pend = 0; man = 0; lamp = 0; last_pres = 0;
    end else begin
      cyc++;
      do_auto = !man;
      if (pend) begin
        pend = 0;
        if (plen >= SW) begin man = !man; lamp = 0; do_auto = 0; end
        else if (man) begin lamp = !lamp; do_auto = 0; end
      end
      if (do_auto) begin
        if (infravermelho) begin lamp = 1; last_pres = cyc; end
        else if (lamp && cyc - last_pres == T) lamp = 0;
      end
      if (push_button != db) begin
        run++;
        if (run == P) begin
          db = !db; run = 0;
          if (db) rise_e = cyc;
          else begin pend = 1; plen = cyc - rise_e; end
        end
      end else run = 0;
    end
    exp_q.push_back({man, lamp});
  end
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({led, saida} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t led,saida=%b required=%b", $time, {led, saida}, e);
      end
    end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(int len);
    push_button = 1; tick(len); push_button = 0; tick(P + 5);
  endtask
  task automatic presence(int len);
    infravermelho = 1; tick(len); infravermelho = 0;
  endtask
  initial begin
    repeat (6) begin
      infravermelho = 1'($urandom_range(0, 1)); push_button = 1'($urandom_range(0, 1)); tick(1);
    end
    infravermelho = 0; push_button = 0; rst = 1; tick(5);
    presence(10); tick(T + 20);
    presence(5); tick(2 * T / 3); presence(1 + $urandom_range(0, 5)); tick(T + 20);
    repeat (20) begin
      push_button = ~push_button; tick(P / 2 + $urandom_range(0, P / 3));
    end
    push_button = 0; tick(P + 5);
    press(SW + P + $urandom_range(0, 100));
    presence(20); tick(10);
    press(P + $urandom_range(10, SW - 100));
    press(P + $urandom_range(10, SW - 100));
    press(SW - 1);
    press(SW);
    press(100);
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) presence($urandom_range(1, 40));
      else press($urandom_range(P + 1, 2 * SW));
      tick($urandom_range(1, T / 4));
    end
    presence(5); tick(3);
    #1 rst = 0;
    #1 checks++;
    if ({led, saida} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset led,saida=%b required=00", {led, saida});
    end
    infravermelho = 1; push_button = 1; tick(4);
    infravermelho = 0; push_button = 0; rst = 1; tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
